// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit, the programming slave and decode.
// The master side drives programming strobes and decode ready; the slave
// side (the fetch unit) returns readback data and the instruction stream.
interface inst_fetch_unit_if #(
  parameter int ADDR_W     = 8,
  parameter int INST_BYTES = 4
);
  logic                    prog_we;
  logic [ADDR_W-1:0]       prog_addr;
  logic [7:0]              prog_wdata;
  logic [7:0]              prog_rdata;
  logic                    inst_ready;
  logic [INST_BYTES*8-1:0] inst;
  logic                    inst_valid;
  logic [ADDR_W-1:0]       inst_pc;

  modport master (
    output prog_we, prog_addr, prog_wdata, inst_ready,
    input  prog_rdata, inst, inst_valid, inst_pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, inst_ready,
    output prog_rdata, inst, inst_valid, inst_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: byte-programmable instruction store plus a
// PROG/RUN/HALT fetch pipeline with valid/ready output, jump and halt word.
// INST_BYTES is assumed to be at least 2 so the byte-lane field is non-empty.
module inst_fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int INST_BYTES = 4,
  parameter int DEPTH      = 64,
  parameter logic [INST_BYTES*8-1:0] HALT_WORD = {(INST_BYTES*8){1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_prog_mode,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_addr,
  output logic              o_halted,
  inst_fetch_unit_if.slave  bus
);

  localparam int WIDTH  = INST_BYTES * 8;
  localparam int LANE_W = $clog2(INST_BYTES);
  localparam int WORD_W = $clog2(DEPTH);
  localparam int MEM_W  = LANE_W + WORD_W;

  // Byte addresses inside the store; everything above is out of range
  localparam logic [ADDR_W-1:0] RANGE_MASK = {ADDR_W{1'b1}} >> (ADDR_W - MEM_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LANE_W;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

  typedef enum logic [1:0] {PROG, RUN, HALT} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] pc, pc_next;
  logic [WIDTH-1:0]  inst_q, inst_next;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_next;
  logic              valid_q, valid_next;
  logic [7:0]        rdata_q;

  logic [WORD_W-1:0] prog_word;
  logic [LANE_W-1:0] prog_lane;
  logic              prog_in_range;
  logic              mem_we;
  logic [WORD_W-1:0] fetch_word_idx;
  logic [WIDTH-1:0]  fetch_word;
  logic [ADDR_W-1:0] jump_target;

  assign prog_word      = bus.prog_addr[MEM_W-1:LANE_W];
  assign prog_lane      = bus.prog_addr[LANE_W-1:0];
  assign prog_in_range  = (bus.prog_addr & ~RANGE_MASK) == '0;
  assign mem_we         = bus.prog_we && i_prog_mode && (state == PROG) && prog_in_range;
  assign fetch_word_idx = pc[MEM_W-1:LANE_W];
  assign fetch_word     = mem[fetch_word_idx];
  assign jump_target    = i_jump_addr & RANGE_MASK & ALIGN_MASK;

  // Byte-lane writes into the store; deliberately not reset so a reset restarts the loaded program
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[prog_word][{prog_lane, 3'b000} +: 8] <= bus.prog_wdata;
    end
  end

  // Registered readback; a same-edge write is not yet visible, so the old byte is returned
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rdata_q <= '0;
    end else if (prog_in_range) begin
      rdata_q <= mem[prog_word][{prog_lane, 3'b000} +: 8];
    end else begin
      rdata_q <= '0;
    end
  end

  // State and fetch pipeline registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= PROG;
      pc        <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= pc_next;
      inst_q    <= inst_next;
      inst_pc_q <= inst_pc_next;
      valid_q   <= valid_next;
    end
  end

  // Next state and datapath: program mode beats jump, jump beats fetch advance
  always_comb begin
    next_state   = state;
    pc_next      = pc;
    inst_next    = inst_q;
    inst_pc_next = inst_pc_q;
    valid_next   = valid_q;
    if (i_prog_mode) begin
      next_state = PROG;
      pc_next    = '0;
      valid_next = 1'b0;
    end else begin
      unique case (state)
        PROG: begin
          next_state = RUN;
        end
        RUN: begin
          if (i_jump) begin
            pc_next    = jump_target;
            valid_next = 1'b0;
          end else if (!valid_q || bus.inst_ready) begin
            if (fetch_word == HALT_WORD) begin
              valid_next = 1'b0;
              next_state = HALT;
            end else begin
              inst_next    = fetch_word;
              inst_pc_next = pc;
              valid_next   = 1'b1;
              pc_next      = (pc + PC_STEP) & RANGE_MASK;
            end
          end
        end
        HALT: begin
          if (i_jump) begin
            pc_next    = jump_target;
            valid_next = 1'b0;
            next_state = RUN;
          end
        end
        default: begin
          next_state = PROG;
          pc_next    = '0;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_rdata = rdata_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = valid_q;
  assign o_halted       = (state == HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: programming, streaming, stall,
// halt/jump, wrap, prog-over-jump priority and async reset. A second small
// instance (DEPTH=16) exercises dropped out-of-range programming writes.
module tb_inst_fetch_unit;

  logic       clk;
  logic       nrst;
  logic       prog_mode;
  logic       jump;
  logic [7:0] jump_addr;
  logic       halted;

  logic       s_jump;
  logic [7:0] s_jump_addr;
  logic       s_halted;

  int checks;
  int errors;

  inst_fetch_unit_if #(.ADDR_W(8), .INST_BYTES(4)) bus ();
  inst_fetch_unit_if #(.ADDR_W(8), .INST_BYTES(4)) sbus ();

  inst_fetch_unit #(.ADDR_W(8), .INST_BYTES(4), .DEPTH(64)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_prog_mode (prog_mode),
    .i_jump      (jump),
    .i_jump_addr (jump_addr),
    .o_halted    (halted),
    .bus         (bus.slave)
  );

  inst_fetch_unit #(.ADDR_W(8), .INST_BYTES(4), .DEPTH(16)) dut_small (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_prog_mode (1'b1),
    .i_jump      (s_jump),
    .i_jump_addr (s_jump_addr),
    .o_halted    (s_halted),
    .bus         (sbus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string tag, input logic [31:0] exp_inst, input logic [7:0] exp_pc);
    check_output({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'd1);
    check_output({tag, "_inst"}, bus.inst, exp_inst);
    check_output({tag, "_pc"}, {24'b0, bus.inst_pc}, {24'b0, exp_pc});
  endtask

  task automatic apply_write(input logic [7:0] addr, input logic [7:0] data);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = addr;
    bus.prog_wdata = data;
    tick();
    bus.prog_we    = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    nrst           = 1'b0;
    prog_mode      = 1'b1;
    jump           = 1'b0;
    jump_addr      = 8'h00;
    s_jump         = 1'b0;
    s_jump_addr    = 8'h00;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = 8'h00;
    bus.prog_wdata = 8'h00;
    bus.inst_ready = 1'b0;
    sbus.prog_we    = 1'b0;
    sbus.prog_addr  = 8'h00;
    sbus.prog_wdata = 8'h00;
    sbus.inst_ready = 1'b0;

    #2;
    check_output("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check_output("rst_inst", bus.inst, 32'h0);
    check_output("rst_pc", {24'b0, bus.inst_pc}, 32'h0);
    check_output("rst_halted", {31'b0, halted}, 32'd0);
    check_output("rst_rdata", {24'b0, bus.prog_rdata}, 32'h0);
    tick();
    nrst = 1'b1;
    tick();

    // T1: program every byte with its own address
    for (int i = 0; i < 256; i++) begin
      apply_write(8'(i), 8'(i));
    end
    bus.prog_addr = 8'h05;
    tick();
    check_output("rdback_5", {24'b0, bus.prog_rdata}, 32'h05);
    bus.prog_addr = 8'hFF;
    tick();
    check_output("rdback_ff", {24'b0, bus.prog_rdata}, 32'hFF);
    bus.prog_addr = 8'h05;
    apply_write(8'h05, 8'h55);
    check_output("rdback_old", {24'b0, bus.prog_rdata}, 32'h05);
    tick();
    check_output("rdback_new", {24'b0, bus.prog_rdata}, 32'h55);
    apply_write(8'h05, 8'h05);

    // T1b: small store holds bytes 0..3F only
    sbus.prog_we    = 1'b1;
    sbus.prog_addr  = 8'hFF;
    sbus.prog_wdata = 8'hAA;
    tick();
    sbus.prog_addr  = 8'h3F;
    sbus.prog_wdata = 8'h5A;
    tick();
    sbus.prog_addr  = 8'h7F;
    sbus.prog_wdata = 8'hC3;
    tick();
    sbus.prog_we    = 1'b0;
    sbus.prog_addr  = 8'hFF;
    tick();
    check_output("small_drop_ff", {24'b0, sbus.prog_rdata}, 32'h00);
    sbus.prog_addr  = 8'h3F;
    tick();
    check_output("small_keep_3f", {24'b0, sbus.prog_rdata}, 32'h5A);

    // T2: run with ready held high
    bus.inst_ready = 1'b1;
    prog_mode      = 1'b0;
    tick();
    check_output("run_first_bubble", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    check_inst("t2_w0", 32'h03020100, 8'h00);
    tick();
    check_inst("t2_w1", 32'h07060504, 8'h04);
    tick();
    check_inst("t2_w2", 32'h0B0A0908, 8'h08);

    // T3: three stalled cycles then resume without skipping
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_inst("t3_stall", 32'h0B0A0908, 8'h08);
    end
    bus.inst_ready = 1'b1;
    tick();
    check_inst("t3_resume", 32'h0F0E0D0C, 8'h0C);
    tick();
    check_inst("t3_next", 32'h13121110, 8'h10);

    // T4: halt word at pc 8, then jump to an unaligned address
    prog_mode = 1'b1;
    tick();
    check_output("t4_prog_valid", {31'b0, bus.inst_valid}, 32'd0);
    for (int i = 8; i < 12; i++) begin
      apply_write(8'(i), 8'hFF);
    end
    prog_mode = 1'b0;
    tick();
    tick();
    check_inst("t4_w0", 32'h03020100, 8'h00);
    tick();
    check_inst("t4_w1", 32'h07060504, 8'h04);
    tick();
    check_output("t4_halted", {31'b0, halted}, 32'd1);
    check_output("t4_halt_valid", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    check_output("t4_still_halted", {31'b0, halted}, 32'd1);
    jump      = 1'b1;
    jump_addr = 8'h01;
    tick();
    jump      = 1'b0;
    check_output("t4_unhalt", {31'b0, halted}, 32'd0);
    check_output("t4_jump_bubble", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    check_inst("t4_resume", 32'h03020100, 8'h00);

    // T5: jump near the top of memory and wrap to word 0
    jump      = 1'b1;
    jump_addr = 8'hF9;
    tick();
    jump      = 1'b0;
    check_output("t5_jump_bubble", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    check_inst("t5_f8", 32'hFBFAF9F8, 8'hF8);
    tick();
    check_inst("t5_fc", 32'hFFFEFDFC, 8'hFC);
    tick();
    check_inst("t5_wrap", 32'h03020100, 8'h00);

    // T5b: program mode and jump on the same edge, program mode wins
    jump      = 1'b1;
    jump_addr = 8'h40;
    prog_mode = 1'b1;
    tick();
    jump      = 1'b0;
    prog_mode = 1'b0;
    check_output("t5b_valid", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    tick();
    check_inst("t5b_pc0", 32'h03020100, 8'h00);
    tick();
    check_inst("t6_pre", 32'h07060504, 8'h04);

    // T6: asynchronous reset mid-stream, memory survives
    #3;
    nrst = 1'b0;
    #1;
    check_output("t6_valid", {31'b0, bus.inst_valid}, 32'd0);
    check_output("t6_inst", bus.inst, 32'h0);
    check_output("t6_pc", {24'b0, bus.inst_pc}, 32'h0);
    check_output("t6_rdata", {24'b0, bus.prog_rdata}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    check_output("t6_bubble", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    check_inst("t6_restart", 32'h03020100, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
